// File: rtl/compressor_input_arbiter.sv
// Packet-granular round-robin arbiter sharing one compressor ingress
// among NUM_CH AXI-stream sources; a grant is held until tlast.
module compressor_input_arbiter #(
  parameter int NUM_CH      = 4,
  parameter int CH_WIDTH    = 2,
  parameter int DATA_WIDTH  = 256,
  parameter int TKEEP_WIDTH = 32
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [NUM_CH-1:0]             cfg_ch_en,
  input  logic [NUM_CH*DATA_WIDTH-1:0]  s_data,
  input  logic [NUM_CH*TKEEP_WIDTH-1:0] s_tkeep,
  input  logic [NUM_CH-1:0]             s_tvalid,
  input  logic [NUM_CH-1:0]             s_tlast,
  output logic [NUM_CH-1:0]             s_tready,
  output logic [DATA_WIDTH-1:0]         m_data,
  output logic [TKEEP_WIDTH-1:0]        m_tkeep,
  output logic                          m_tvalid,
  output logic                          m_tlast,
  output logic                          m_first,
  output logic [CH_WIDTH-1:0]           m_ch,
  input  logic                          m_tready,
  output logic                          busy,
  output logic [15:0]                   pkt_cnt
);

  typedef enum logic {IDLE, XFER} state_t;

  state_t                   state_q, state_d;
  logic [CH_WIDTH-1:0]      grant_q, grant_d;
  logic [CH_WIDTH-1:0]      last_grant_q, last_grant_d;
  logic                     first_pend_q, first_pend_d;
  logic [DATA_WIDTH-1:0]    m_data_q, m_data_d;
  logic [TKEEP_WIDTH-1:0]   m_tkeep_q, m_tkeep_d;
  logic                     m_tvalid_q, m_tvalid_d;
  logic                     m_tlast_q, m_tlast_d;
  logic                     m_first_q, m_first_d;
  logic [CH_WIDTH-1:0]      m_ch_q, m_ch_d;
  logic [15:0]              pkt_cnt_q, pkt_cnt_d;

  logic [NUM_CH-1:0]        req;
  logic                     ld;
  logic                     acc;
  logic                     found;
  logic [CH_WIDTH-1:0]      pick;
  int                       idx;

  assign req = s_tvalid & cfg_ch_en;
  assign ld  = !m_tvalid_q || m_tready;
  assign acc = (state_q == XFER) && s_tvalid[grant_q] && ld;

  // search starts one past the last packet's channel
  always_comb begin
    found = 1'b0;
    pick  = last_grant_q;
    idx   = 0;
    for (int k = 1; k <= NUM_CH; k++) begin
      idx = (int'(last_grant_q) + k) % NUM_CH;
      if (!found && req[CH_WIDTH'(idx)]) begin
        found = 1'b1;
        pick  = CH_WIDTH'(idx);
      end
    end
  end

  always_comb begin
    s_tready = '0;
    if (state_q == XFER) s_tready[grant_q] = ld;
  end

  always_comb begin
    state_d      = state_q;
    grant_d      = grant_q;
    last_grant_d = last_grant_q;
    first_pend_d = first_pend_q;
    m_data_d     = m_data_q;
    m_tkeep_d    = m_tkeep_q;
    m_tvalid_d   = m_tvalid_q;
    m_tlast_d    = m_tlast_q;
    m_first_d    = m_first_q;
    m_ch_d       = m_ch_q;
    pkt_cnt_d    = pkt_cnt_q;
    unique case (state_q)
      IDLE: begin
        if (found) begin
          grant_d      = pick;
          first_pend_d = 1'b1;
          state_d      = XFER;
        end
      end
      XFER: begin
        if (acc) begin
          first_pend_d = 1'b0;
          if (s_tlast[grant_q]) begin
            last_grant_d = grant_q;
            pkt_cnt_d    = pkt_cnt_q + 16'd1;
            state_d      = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
    if (ld) begin
      m_tvalid_d = acc;
      if (acc) begin
        m_data_d  = s_data[int'(grant_q)*DATA_WIDTH +: DATA_WIDTH];
        m_tkeep_d = s_tkeep[int'(grant_q)*TKEEP_WIDTH +: TKEEP_WIDTH];
        m_tlast_d = s_tlast[grant_q];
        m_first_d = first_pend_q;
        m_ch_d    = grant_q;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= IDLE;
      grant_q      <= '0;
      last_grant_q <= CH_WIDTH'(NUM_CH - 1);
      first_pend_q <= 1'b0;
      m_data_q     <= '0;
      m_tkeep_q    <= '0;
      m_tvalid_q   <= 1'b0;
      m_tlast_q    <= 1'b0;
      m_first_q    <= 1'b0;
      m_ch_q       <= '0;
      pkt_cnt_q    <= '0;
    end else begin
      state_q      <= state_d;
      grant_q      <= grant_d;
      last_grant_q <= last_grant_d;
      first_pend_q <= first_pend_d;
      m_data_q     <= m_data_d;
      m_tkeep_q    <= m_tkeep_d;
      m_tvalid_q   <= m_tvalid_d;
      m_tlast_q    <= m_tlast_d;
      m_first_q    <= m_first_d;
      m_ch_q       <= m_ch_d;
      pkt_cnt_q    <= pkt_cnt_d;
    end
  end

  assign m_data   = m_data_q;
  assign m_tkeep  = m_tkeep_q;
  assign m_tvalid = m_tvalid_q;
  assign m_tlast  = m_tlast_q;
  assign m_first  = m_first_q;
  assign m_ch     = m_ch_q;
  assign busy     = (state_q == XFER);
  assign pkt_cnt  = pkt_cnt_q;

endmodule

// File: tb/tb_compressor_input_arbiter.sv
// Bench for compressor_input_arbiter: per-channel source queues,
// output beat log, and per-scenario checks against the queued packets.
module tb_compressor_input_arbiter;

  localparam int NC = 4;
  localparam int CW = 2;
  localparam int DW = 256;
  localparam int KW = 32;

  logic             clk = 1'b0;
  logic             reset = 1'b0;
  logic [NC-1:0]    cfg_ch_en;
  logic [NC*DW-1:0] s_data;
  logic [NC*KW-1:0] s_tkeep;
  logic [NC-1:0]    s_tvalid;
  logic [NC-1:0]    s_tlast;
  logic [NC-1:0]    s_tready;
  logic [DW-1:0]    m_data;
  logic [KW-1:0]    m_tkeep;
  logic             m_tvalid;
  logic             m_tlast;
  logic             m_first;
  logic [CW-1:0]    m_ch;
  logic             m_tready;
  logic             busy;
  logic [15:0]      pkt_cnt;

  compressor_input_arbiter #(
    .NUM_CH(NC), .CH_WIDTH(CW), .DATA_WIDTH(DW), .TKEEP_WIDTH(KW)
  ) dut (
    .clk(clk), .reset(reset), .cfg_ch_en(cfg_ch_en),
    .s_data(s_data), .s_tkeep(s_tkeep), .s_tvalid(s_tvalid),
    .s_tlast(s_tlast), .s_tready(s_tready),
    .m_data(m_data), .m_tkeep(m_tkeep), .m_tvalid(m_tvalid),
    .m_tlast(m_tlast), .m_first(m_first), .m_ch(m_ch),
    .m_tready(m_tready), .busy(busy), .pkt_cnt(pkt_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [DW-1:0] data;
    logic [KW-1:0] keep;
    logic          last;
  } beat_t;

  typedef struct {
    int            ch;
    logic [DW-1:0] data;
    logic [KW-1:0] keep;
    logic          last;
    logic          first;
    int            cyc;
    int            pkt;
  } obs_t;

  beat_t   src_q [NC][$];
  beat_t   mdl_q [NC][$];
  obs_t    obs_q [$];
  logic [NC-1:0] gate;
  bit      rnd_mode;
  int      cyc;
  int      n_checks;
  int      n_fail;

  task automatic drive();
    s_tvalid = '0;
    s_tlast  = '0;
    for (int i = 0; i < NC; i++) begin
      if (src_q[i].size() > 0 && gate[i]) begin
        s_tvalid[i] = 1'b1;
        s_tlast[i]  = src_q[i][0].last;
        s_data[i*DW +: DW] = src_q[i][0].data;
        s_tkeep[i*KW +: KW] = src_q[i][0].keep;
      end
    end
  endtask

  task automatic add_pkt(input int ch, input int len);
    beat_t bt;
    for (int b = 0; b < len; b++) begin
      for (int w = 0; w < DW/32; w++) bt.data[w*32 +: 32] = $urandom();
      bt.keep = $urandom();
      bt.last = (b == len - 1);
      src_q[ch].push_back(bt);
      mdl_q[ch].push_back(bt);
    end
  endtask

  task automatic clear_q();
    for (int i = 0; i < NC; i++) begin
      src_q[i].delete();
      mdl_q[i].delete();
    end
    obs_q.delete();
  endtask

  // one clock: sample at negedge, advance sources after posedge
  task automatic step();
    logic [NC-1:0] hs;
    obs_t o;
    @(negedge clk);
    cyc++;
    hs = s_tvalid & s_tready;
    if (m_tvalid && m_tready) begin
      o.ch = int'(m_ch); o.data = m_data; o.keep = m_tkeep;
      o.last = m_tlast; o.first = m_first; o.cyc = cyc;
      o.pkt = int'(pkt_cnt);
      obs_q.push_back(o);
    end
    @(posedge clk);
    #1;
    for (int i = 0; i < NC; i++)
      if (hs[i]) void'(src_q[i].pop_front());
    if (rnd_mode) begin
      for (int i = 0; i < NC; i++) gate[i] = ($urandom_range(0, 3) != 0);
      m_tready = ($urandom_range(0, 9) < 7);
    end
    drive();
  endtask

  task automatic run(input int n, input int max_steps);
    int k = 0;
    while (obs_q.size() < n && k < max_steps) begin
      step();
      k++;
    end
  endtask

  task automatic do_reset();
    reset = 1'b0;
    m_tready = 1'b1;
    cfg_ch_en = '1;
    gate = '1;
    rnd_mode = 1'b0;
    clear_q();
    drive();
    repeat (2) @(posedge clk);
    #1 reset = 1'b1;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    m_tready = 1'b1;
    cfg_ch_en = '1;
    gate = '1;
    clear_q();
    add_pkt(0, 2);
    drive();
    @(posedge clk);
    #1;
    n_checks++;
    if ({m_tvalid, m_tlast, m_first, busy} !== 4'b0) begin
      n_fail++;
      $display("FAIL reset_flags: got %b want 0000",
               {m_tvalid, m_tlast, m_first, busy});
    end
    n_checks++;
    if (m_data !== '0 || m_tkeep !== '0 || m_ch !== '0) begin
      n_fail++;
      $display("FAIL reset_data: got ch=%0d keep=%h want 0", m_ch, m_tkeep);
    end
    n_checks++;
    if (s_tready !== '0 || pkt_cnt !== 16'd0) begin
      n_fail++;
      $display("FAIL reset_rdy_cnt: got rdy=%b cnt=%0d want 0 0",
               s_tready, pkt_cnt);
    end
  endtask

  task automatic test_basic();
    int t0;
    do_reset();
    add_pkt(2, 3);
    drive();
    t0 = cyc + 1;
    run(3, 20);
    n_checks++;
    if (obs_q.size() != 3) begin
      n_fail++;
      $display("FAIL basic_count: got %0d want 3", obs_q.size());
    end
    for (int k = 0; k < obs_q.size() && k < 3; k++) begin
      n_checks++;
      if (obs_q[k].ch != 2 || obs_q[k].data !== mdl_q[2][k].data ||
          obs_q[k].first !== (k == 0) || obs_q[k].last !== (k == 2) ||
          obs_q[k].cyc != t0 + 2 + k) begin
        n_fail++;
        $display("FAIL basic_beat%0d: got ch=%0d f=%b l=%b cyc=%0d want ch=2 f=%b l=%b cyc=%0d",
                 k, obs_q[k].ch, obs_q[k].first, obs_q[k].last,
                 obs_q[k].cyc, k == 0, k == 2, t0 + 2 + k);
      end
    end
    n_checks++;
    if (pkt_cnt !== 16'd1) begin
      n_fail++;
      $display("FAIL basic_pkt_cnt: got %0d want 1", pkt_cnt);
    end
  endtask

  task automatic test_round_robin();
    do_reset();
    for (int r = 0; r < 2; r++)
      for (int c = 0; c < NC; c++) add_pkt(c, 1);
    drive();
    run(8, 40);
    n_checks++;
    if (obs_q.size() != 8) begin
      n_fail++;
      $display("FAIL rr_count: got %0d want 8", obs_q.size());
    end
    for (int k = 0; k < obs_q.size() && k < 8; k++) begin
      n_checks++;
      if (obs_q[k].ch != k % NC || obs_q[k].pkt != k + 1 ||
          (k > 0 && obs_q[k].cyc - obs_q[k-1].cyc != 2)) begin
        n_fail++;
        $display("FAIL rr_beat%0d: got ch=%0d cnt=%0d want ch=%0d cnt=%0d",
                 k, obs_q[k].ch, obs_q[k].pkt, k % NC, k + 1);
      end
    end
  endtask

  task automatic test_no_interleave();
    int exp_ch [6] = '{0, 0, 0, 0, 1, 1};
    int exp_gap [6] = '{0, 1, 1, 1, 2, 1};
    int exp_ix [6] = '{0, 1, 2, 3, 0, 1};
    do_reset();
    add_pkt(0, 4);
    drive();
    step();
    step();
    add_pkt(1, 2);
    drive();
    run(6, 40);
    n_checks++;
    if (obs_q.size() != 6) begin
      n_fail++;
      $display("FAIL hold_count: got %0d want 6", obs_q.size());
    end
    for (int k = 0; k < obs_q.size() && k < 6; k++) begin
      n_checks++;
      if (obs_q[k].ch != exp_ch[k] ||
          obs_q[k].data !== mdl_q[exp_ch[k]][exp_ix[k]].data ||
          (k > 0 && obs_q[k].cyc - obs_q[k-1].cyc != exp_gap[k])) begin
        n_fail++;
        $display("FAIL hold_beat%0d: got ch=%0d want ch=%0d gap %0d",
                 k, obs_q[k].ch, exp_ch[k], exp_gap[k]);
      end
    end
  endtask

  task automatic test_backpressure();
    logic [DW-1:0] held;
    do_reset();
    add_pkt(3, 6);
    drive();
    run(1, 20);
    m_tready = 1'b0;
    held = m_data;
    n_checks++;
    if (held !== mdl_q[3][1].data || m_tvalid !== 1'b1) begin
      n_fail++;
      $display("FAIL bp_held: got v=%b data=%h want v=1 beat1", m_tvalid, held[31:0]);
    end
    for (int k = 0; k < 5; k++) begin
      step();
      n_checks++;
      if (m_data !== held || m_ch !== 2'd3 || m_tvalid !== 1'b1 ||
          s_tready !== '0 || busy !== 1'b1) begin
        n_fail++;
        $display("FAIL bp_stall%0d: got ch=%0d v=%b rdy=%b busy=%b want 3 1 0000 1",
                 k, m_ch, m_tvalid, s_tready, busy);
      end
    end
    m_tready = 1'b1;
    run(6, 40);
    n_checks++;
    if (obs_q.size() != 6) begin
      n_fail++;
      $display("FAIL bp_count: got %0d want 6", obs_q.size());
    end
    for (int k = 0; k < obs_q.size() && k < 6; k++) begin
      n_checks++;
      if (obs_q[k].data !== mdl_q[3][k].data || obs_q[k].last !== (k == 5)) begin
        n_fail++;
        $display("FAIL bp_beat%0d: got l=%b want l=%b (data order)",
                 k, obs_q[k].last, k == 5);
      end
    end
  endtask

  task automatic test_cfg_enable();
    int exp_ch [8] = '{1, 1, 3, 3, 1, 1, 3, 3};
    int ix [NC];
    do_reset();
    cfg_ch_en = 4'b1010;
    for (int c = 0; c < NC; c++) begin
      add_pkt(c, 2);
      add_pkt(c, 2);
    end
    add_pkt(1, 2);
    drive();
    run(5, 40);
    cfg_ch_en[1] = 1'b0;
    repeat (30) step();
    n_checks++;
    if (obs_q.size() != 8 || pkt_cnt !== 16'd4) begin
      n_fail++;
      $display("FAIL en_count: got beats=%0d cnt=%0d want 8 4",
               obs_q.size(), pkt_cnt);
    end
    for (int c = 0; c < NC; c++) ix[c] = 0;
    for (int k = 0; k < obs_q.size() && k < 8; k++) begin
      n_checks++;
      if (obs_q[k].ch != exp_ch[k] ||
          obs_q[k].data !== mdl_q[exp_ch[k]][ix[exp_ch[k]]].data) begin
        n_fail++;
        $display("FAIL en_beat%0d: got ch=%0d want ch=%0d",
                 k, obs_q[k].ch, exp_ch[k]);
      end
      ix[exp_ch[k]]++;
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    add_pkt(2, 4);
    drive();
    run(2, 20);
    reset = 1'b0;
    #1;
    n_checks++;
    if (m_tvalid !== 1'b0 || m_data !== '0 || m_ch !== '0 ||
        busy !== 1'b0 || pkt_cnt !== 16'd0 || s_tready !== '0) begin
      n_fail++;
      $display("FAIL rst_mid: got v=%b ch=%0d busy=%b cnt=%0d rdy=%b want all 0",
               m_tvalid, m_ch, busy, pkt_cnt, s_tready);
    end
    clear_q();
    drive();
    @(posedge clk);
    #1 reset = 1'b1;
    for (int c = 0; c < NC; c++) add_pkt(c, 1);
    drive();
    run(1, 20);
    n_checks++;
    if (obs_q.size() != 1 || obs_q[0].ch != 0 || obs_q[0].pkt != 1) begin
      n_fail++;
      $display("FAIL rst_regrant: got beats=%0d ch=%0d want 1 ch=0",
               obs_q.size(), obs_q.size() > 0 ? obs_q[0].ch : -1);
    end
  endtask

  task automatic test_random();
    int total = 0;
    int npk = 0;
    int ix [NC];
    int open = -1;
    int bad = 0;
    bit exp_first;
    do_reset();
    for (int c = 0; c < NC; c++) begin
      int np = $urandom_range(2, 5);
      for (int p = 0; p < np; p++) begin
        int len = $urandom_range(1, 4);
        add_pkt(c, len);
        total += len;
        npk++;
      end
    end
    rnd_mode = 1'b1;
    drive();
    run(total, 4000);
    rnd_mode = 1'b0;
    m_tready = 1'b1;
    n_checks++;
    if (obs_q.size() != total || pkt_cnt !== 16'(npk)) begin
      n_fail++;
      $display("FAIL rnd_count: got beats=%0d cnt=%0d want %0d %0d",
               obs_q.size(), pkt_cnt, total, npk);
    end
    for (int c = 0; c < NC; c++) ix[c] = 0;
    foreach (obs_q[k]) begin
      int c = obs_q[k].ch;
      n_checks++;
      if (ix[c] >= mdl_q[c].size()) begin
        n_fail++;
        $display("FAIL rnd_extra%0d: got beat on ch%0d want none", k, c);
      end else begin
        exp_first = (ix[c] == 0) || mdl_q[c][ix[c]-1].last;
        if (obs_q[k].data !== mdl_q[c][ix[c]].data ||
            obs_q[k].keep !== mdl_q[c][ix[c]].keep ||
            obs_q[k].last !== mdl_q[c][ix[c]].last ||
            obs_q[k].first !== exp_first || (open != -1 && open != c)) begin
          n_fail++;
          bad++;
          if (bad < 5)
            $display("FAIL rnd_beat%0d: got ch=%0d f=%b l=%b want f=%b l=%b open=%0d",
                     k, c, obs_q[k].first, obs_q[k].last, exp_first,
                     mdl_q[c][ix[c]].last, open);
        end
        ix[c]++;
      end
      open = obs_q[k].last ? -1 : c;
    end
  endtask

  initial begin
    n_checks = 0;
    n_fail = 0;
    cyc = 0;
    rnd_mode = 1'b0;
    gate = '1;
    m_tready = 1'b1;
    cfg_ch_en = '1;
    s_data = '0;
    s_tkeep = '0;
    s_tvalid = '0;
    s_tlast = '0;
    test_reset();
    test_basic();
    test_round_robin();
    test_no_interleave();
    test_backpressure();
    test_cfg_enable();
    test_reset_mid();
    for (int r = 0; r < 4; r++) test_random();
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule
